serial_prefix_encoder: RTL

- Transmit-side counterpart of the team's serial codeword decoders.
- Accepts 2-bit symbols over a valid/ready handshake and emits each one MSB-first as a variable-length prefix codeword on a 1-bit serial line.
- Flags the final bit of each codeword and supports downstream back-pressure.
- Produces the bit streams that the serial decoder benches consume.

---
 rtl/serial_prefix_encoder.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_prefix_encoder.sv
// Purpose : encodes 2-bit symbols into left-justified prefix codewords sent MSB-first on a 1-bit line.
// Latency : first codeword bit is visible the cycle after the symbol is accepted.
// Backpressure: out_ready low freezes x/x_valid/x_last; sym_ready reopens only on the final-bit transfer.
module serial_prefix_encoder #(
    parameter int               MAXLEN = 4,
    parameter logic [MAXLEN-1:0] CODE0 = 4'b0000,
    parameter logic [MAXLEN-1:0] CODE1 = 4'b1000,
    parameter logic [MAXLEN-1:0] CODE2 = 4'b1100,
    parameter logic [MAXLEN-1:0] CODE3 = 4'b1110,
    parameter int               LEN0   = 1,
    parameter int               LEN1   = 2,
    parameter int               LEN2   = 3,
    parameter int               LEN3   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sym,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic       out_ready,
    output logic       x,
    output logic       x_valid,
    output logic       x_last,
    output logic       busy,
    output logic [7:0] sym_count
);

    // Bit counter only ever holds LEN-1, so log2(MAXLEN) bits suffice.
    localparam int CW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q;
    // Holds the bits still to be sent after the one currently on x.
    logic [MAXLEN-1:0] shift_q;
    // Number of bits remaining after the one currently on x.
    logic [CW-1:0]     cnt_q;
    logic              x_q;
    logic              x_valid_q;
    logic              x_last_q;
    logic [7:0]        sym_count_q;

    logic [MAXLEN-1:0] load_code;
    int                load_len;
    logic              accept;
    logic              xfer;

    // Codeword and length lookup for the symbol currently offered.
    always_comb begin
        load_code = CODE0;
        load_len  = LEN0;
        case (sym)
            2'd0: begin load_code = CODE0; load_len = LEN0; end
            2'd1: begin load_code = CODE1; load_len = LEN1; end
            2'd2: begin load_code = CODE2; load_len = LEN2; end
            default: begin load_code = CODE3; load_len = LEN3; end
        endcase
    end

    // A new symbol can enter when idle, or exactly as the last bit of the current codeword leaves.
    assign sym_ready = rst_n && ((state_q == IDLE) || (x_valid_q && x_last_q && out_ready));
    assign accept    = sym_valid && sym_ready;
    assign xfer      = x_valid_q && out_ready;

    // Encoder FSM: loads codewords, shifts bits out on each transfer, counts completed codewords.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            x_last_q    <= 1'b0;
            sym_count_q <= 8'd0;
        end else begin
            if (xfer && x_last_q) begin
                sym_count_q <= sym_count_q + 8'd1;
            end
            if (accept) begin
                // Same load path whether coming from IDLE or chaining behind a final bit.
                state_q   <= SEND;
                x_q       <= load_code[MAXLEN-1];
                shift_q   <= {load_code[MAXLEN-2:0], 1'b0};
                cnt_q     <= CW'(load_len - 1);
                x_valid_q <= 1'b1;
                x_last_q  <= (load_len == 1);
            end else if (xfer) begin
                if (x_last_q) begin
                    state_q   <= IDLE;
                    x_q       <= 1'b0;
                    x_valid_q <= 1'b0;
                    x_last_q  <= 1'b0;
                    shift_q   <= '0;
                    cnt_q     <= '0;
                end else begin
                    x_q      <= shift_q[MAXLEN-1];
                    shift_q  <= {shift_q[MAXLEN-2:0], 1'b0};
                    cnt_q    <= cnt_q - CW'(1);
                    x_last_q <= (cnt_q == CW'(1));
                end
            end
        end
    end

    assign x         = x_q;
    assign x_valid   = x_valid_q;
    assign x_last    = x_last_q;
    assign busy      = (state_q == SEND);
    assign sym_count = sym_count_q;

endmodule
